// File: rtl/kgp_prefix_adder_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | kgp_prefix_adder_pipe_if                                             |
// | Operand/result stream bundle for the pipelined KPG prefix adder.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface kgp_prefix_adder_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/kgp_prefix_adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | kgp_prefix_adder_pipe                                                |
// | Three-stage Kogge-Stone adder: KPG encode, prefix tree, sum form.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+

// 2-bit KPG combine: a kill/generate on the high side dominates.
module kgp_prefix_cell (
  input  logic [1:0] i_hi,
  input  logic [1:0] i_lo,
  output logic [1:0] o_res
);
  assign o_res = (i_hi[1] == i_hi[0]) ? i_hi : i_lo;
endmodule

module kgp_prefix_adder_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  kgp_prefix_adder_pipe_if.slave bus
);
  localparam int c_npos   = WIDTH + 1;
  localparam int c_levels = $clog2(WIDTH + 1);

  logic                   w_advance;
  logic [c_npos-1:0][1:0] w_kpg_enc;
  logic [c_npos-1:0][1:0] w_resolved;
  logic [WIDTH-1:0]       w_carry;
  logic [c_npos-1:0]      w_code_hi;
  logic                   w_unused_code_hi;

  logic [c_npos-1:0][1:0] r_kpg1;
  logic [c_npos-1:0][1:0] r_kpg2;
  logic [WIDTH-1:0]       r_hs1;
  logic [WIDTH-1:0]       r_hs2;
  logic [WIDTH-1:0]       r_sum;
  logic                   r_cout;
  logic                   r_v1;
  logic                   r_v2;
  logic                   r_v3;

  assign w_advance     = ~r_v3 | bus.out_ready;
  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_v3;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;

  // Index 0 is the carry-in pseudo-position; operand bit i sits at index i+1.
  assign w_kpg_enc[0] = {bus.cin, bus.cin};

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_enc
      assign w_kpg_enc[gi+1] = {bus.a[gi], bus.b[gi]};
    end
  endgenerate

  generate
    for (genvar gk = 0; gk < c_levels; gk++) begin : g_level
      logic [c_npos-1:0][1:0] w_in;
      logic [c_npos-1:0][1:0] w_out;

      if (gk == 0) begin : g_first
        assign w_in = r_kpg1;
      end else begin : g_next
        assign w_in = g_level[gk-1].w_out;
      end

      for (genvar gp = 0; gp < c_npos; gp++) begin : g_pos
        if (gp >= (1 << gk)) begin : g_cell
          kgp_prefix_cell u_cell (
            .i_hi  (w_in[gp]),
            .i_lo  (w_in[gp - (1 << gk)]),
            .o_res (w_out[gp])
          );
        end else begin : g_pass
          assign w_out[gp] = w_in[gp];
        end
      end
    end
  endgenerate

  assign w_resolved = g_level[c_levels-1].w_out;

  // Resolved codes are pure kill/generate, so bit 0 alone carries the carry.
  generate
    for (genvar gc = 0; gc < WIDTH; gc++) begin : g_carry
      assign w_carry[gc] = r_kpg2[gc][0];
    end
    for (genvar gh = 0; gh < c_npos; gh++) begin : g_code_hi
      assign w_code_hi[gh] = r_kpg2[gh][1];
    end
  endgenerate

  assign w_unused_code_hi = ^w_code_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_kpg1 <= '0;
      r_kpg2 <= '0;
      r_hs1  <= '0;
      r_hs2  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_advance) begin
      r_v1   <= bus.in_valid;
      r_kpg1 <= w_kpg_enc;
      r_hs1  <= bus.a ^ bus.b;
      r_v2   <= r_v1;
      r_kpg2 <= w_resolved;
      r_hs2  <= r_hs1;
      r_v3   <= r_v2;
      r_sum  <= r_hs2 ^ w_carry;
      r_cout <= r_kpg2[WIDTH][0];
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_kgp_prefix_adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_kgp_prefix_adder_pipe                                             |
// | Directed and random checks of the pipelined adder at WIDTH 8 and 13. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_kgp_prefix_adder_pipe;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  kgp_prefix_adder_pipe_if #(.WIDTH(8))  bus8 ();
  kgp_prefix_adder_pipe_if #(.WIDTH(13)) bus13 ();

  kgp_prefix_adder_pipe #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  kgp_prefix_adder_pipe #(.WIDTH(13)) dut13 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus13.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Random-phase state, index 0 = WIDTH 8, index 1 = WIDTH 13.
  int          wid  [2];
  logic [63:0] mask [2];
  logic [63:0] r_a  [2];
  logic [63:0] r_b  [2];
  logic        r_ci [2];
  logic        r_iv [2];
  logic        r_or [2];
  logic        r_acc[2];
  logic        o_v  [2];
  logic [63:0] o_s  [2];
  logic        o_c  [2];
  logic        ir   [2];
  logic        p_ov [2];
  logic        p_or [2];
  logic [63:0] p_s  [2];
  logic        p_c  [2];
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                       input logic [7:0] es, input logic ec, input string tag);
    bus8.a = ta; bus8.b = tb_v; bus8.cin = tc;
    bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, 64'(bus8.out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_lat2_valid"}, 64'(bus8.out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_lat3_valid"}, 64'(bus8.out_valid), 64'd1);
    chk({tag, "_sum"},        64'(bus8.sum),       64'(es));
    chk({tag, "_cout"},       64'(bus8.cout),      64'(ec));
  endtask

  task automatic drive8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc);
    bus8.a = ta; bus8.b = tb_v; bus8.cin = tc; bus8.in_valid = 1'b1;
  endtask

  task automatic expect8(input logic [7:0] es, input logic ec, input string tag);
    chk({tag, "_valid"}, 64'(bus8.out_valid), 64'd1);
    chk({tag, "_sum"},   64'(bus8.sum),       64'(es));
    chk({tag, "_cout"},  64'(bus8.cout),      64'(ec));
  endtask

  task automatic rnd_cycle(input bit drain);
    logic [63:0] e;
    @(negedge clk);
    o_v[0] = bus8.out_valid;  o_s[0] = 64'(bus8.sum);  o_c[0] = bus8.cout;
    o_v[1] = bus13.out_valid; o_s[1] = 64'(bus13.sum); o_c[1] = bus13.cout;
    for (int d = 0; d < 2; d++) begin
      if (p_ov[d] && !p_or[d]) begin
        chk($sformatf("w%0d_stall_valid", wid[d]), 64'(o_v[d]), 64'd1);
        chk($sformatf("w%0d_stall_sum", wid[d]),   o_s[d],      p_s[d]);
        chk($sformatf("w%0d_stall_cout", wid[d]),  64'(o_c[d]), 64'(p_c[d]));
      end
      if (drain) begin
        r_iv[d] = 1'b0;
        r_or[d] = 1'b1;
      end else begin
        if (!(r_iv[d] && !r_acc[d])) begin
          r_iv[d] = ($urandom_range(0, 3) != 0);
          r_a[d]  = {$urandom, $urandom} & mask[d];
          r_b[d]  = {$urandom, $urandom} & mask[d];
          r_ci[d] = 1'($urandom_range(0, 1));
        end
        r_or[d] = ($urandom_range(0, 3) != 0);
      end
    end
    bus8.in_valid  = r_iv[0]; bus8.a  = r_a[0][7:0];  bus8.b  = r_b[0][7:0];
    bus8.cin       = r_ci[0]; bus8.out_ready  = r_or[0];
    bus13.in_valid = r_iv[1]; bus13.a = r_a[1][12:0]; bus13.b = r_b[1][12:0];
    bus13.cin      = r_ci[1]; bus13.out_ready = r_or[1];
    #1;
    ir[0] = bus8.in_ready;
    ir[1] = bus13.in_ready;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("w%0d_in_ready", wid[d]), 64'(ir[d]), 64'(!o_v[d] || r_or[d]));
      if (o_v[d] && r_or[d]) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          chk($sformatf("w%0d_extra_output", wid[d]), 64'd1, 64'd0);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("w%0d_sum", wid[d]),  o_s[d],      e & mask[d]);
          chk($sformatf("w%0d_cout", wid[d]), 64'(o_c[d]), (e >> wid[d]) & 64'd1);
        end
      end
      r_acc[d] = r_iv[d] && ir[d];
      if (r_acc[d]) begin
        e = r_a[d] + r_b[d] + 64'(r_ci[d]);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
      p_ov[d] = o_v[d]; p_or[d] = r_or[d]; p_s[d] = o_s[d]; p_c[d] = o_c[d];
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    wid[0] = 8;  mask[0] = 64'hFF;
    wid[1] = 13; mask[1] = 64'h1FFF;
    reset = 1'b1;
    bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.out_ready  = 1'b1;
    bus13.in_valid = 1'b0; bus13.a = '0; bus13.b = '0; bus13.cin = 1'b0; bus13.out_ready = 1'b1;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid",   64'(bus8.out_valid),  64'd0);
    chk("rst_sum",         64'(bus8.sum),        64'd0);
    chk("rst_cout",        64'(bus8.cout),       64'd0);
    chk("rst_in_ready",    64'(bus8.in_ready),   64'd1);
    chk("rst_w13_valid",   64'(bus13.out_valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Latency and carry-chain corner cases.
    send8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
    send8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ff_plus_1");
    send8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "ff_plus_cin");
    send8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "msb_gen");

    // Back-to-back stream.
    drive8(8'h12, 8'h34, 1'b0);
    @(negedge clk); drive8(8'hF0, 8'h0F, 1'b1);
    @(negedge clk); drive8(8'h7F, 8'h01, 1'b0);
    @(negedge clk); bus8.in_valid = 1'b0;
    expect8(8'h46, 1'b0, "stream0");
    @(negedge clk); expect8(8'h00, 1'b1, "stream1");
    @(negedge clk); expect8(8'h80, 1'b0, "stream2");
    @(negedge clk); chk("stream_end_valid", 64'(bus8.out_valid), 64'd0);

    // Backpressure with a full pipeline and a held input.
    drive8(8'h01, 8'h02, 1'b0);
    @(negedge clk); drive8(8'h10, 8'h20, 1'b1);
    @(negedge clk); drive8(8'hFF, 8'hFF, 1'b1);
    @(negedge clk);
    expect8(8'h03, 1'b0, "bp_first");
    bus8.out_ready = 1'b0;
    drive8(8'h55, 8'hAA, 1'b1);
    #1 chk("bp_in_ready", 64'(bus8.in_ready), 64'd0);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      expect8(8'h03, 1'b0, $sformatf("bp_hold%0d", s));
      chk($sformatf("bp_hold%0d_in_ready", s), 64'(bus8.in_ready), 64'd0);
    end
    bus8.out_ready = 1'b1;
    @(negedge clk); bus8.in_valid = 1'b0;
    expect8(8'h31, 1'b0, "bp_second");
    @(negedge clk); expect8(8'hFF, 1'b1, "bp_third");
    @(negedge clk); expect8(8'h00, 1'b1, "bp_held_input");
    @(negedge clk); chk("bp_no_dup", 64'(bus8.out_valid), 64'd0);

    // Asynchronous reset with three operations in flight.
    drive8(8'h11, 8'h22, 1'b0);
    @(negedge clk); drive8(8'h33, 8'h44, 1'b0);
    @(negedge clk); drive8(8'h55, 8'h66, 1'b1);
    @(negedge clk); bus8.in_valid = 1'b0;
    chk("arst_pre_valid", 64'(bus8.out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid",    64'(bus8.out_valid), 64'd0);
    chk("arst_sum",      64'(bus8.sum),       64'd0);
    chk("arst_cout",     64'(bus8.cout),      64'd0);
    chk("arst_in_ready", 64'(bus8.in_ready),  64'd1);
    @(negedge clk);
    reset = 1'b0;
    send8(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, "post_rst");
    @(negedge clk);
    chk("post_rst_no_replay", 64'(bus8.out_valid), 64'd0);

    // Random traffic on both widths against the arithmetic reference.
    for (int d = 0; d < 2; d++) begin
      r_iv[d] = 1'b0; r_acc[d] = 1'b1; r_or[d] = 1'b1;
      r_a[d] = '0; r_b[d] = '0; r_ci[d] = 1'b0;
      p_ov[d] = 1'b0; p_or[d] = 1'b1; p_s[d] = '0; p_c[d] = 1'b0;
    end
    for (int n = 0; n < 20000; n++) rnd_cycle(1'b0);
    for (int n = 0; n < 8; n++)     rnd_cycle(1'b1);
    chk("w8_results_left",  64'(q0.size()), 64'd0);
    chk("w13_results_left", 64'(q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
